// File: rtl/echo_indication_p2m.sv
// Pipe-to-method demarshaller for EchoIndication: reassembles header+payload words
// from the inbound pipe and dispatches one heard/heard2/heard3 call per valid message.
module echo_indication_p2m #(
    parameter int ERR_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 pipe_enq__ENA,
    input  logic [31:0]          pipe_enq_v,
    output logic                 pipe_enq__RDY,
    output logic                 method_heard__ENA,
    output logic [31:0]          method_heard_v,
    input  logic                 method_heard__RDY,
    output logic                 method_heard2__ENA,
    output logic [15:0]          method_heard2_a,
    output logic [15:0]          method_heard2_b,
    input  logic                 method_heard2__RDY,
    output logic                 method_heard3__ENA,
    output logic [15:0]          method_heard3_a,
    output logic [31:0]          method_heard3_b,
    output logic [31:0]          method_heard3_c,
    output logic [15:0]          method_heard3_d,
    input  logic                 method_heard3__RDY,
    output logic [ERR_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        HDR      = 2'd0,
        BODY     = 2'd1,
        DISCARD  = 2'd2,
        DISPATCH = 2'd3
    } state_t;

    localparam logic [15:0] IDX_HEARD  = 16'd0;
    localparam logic [15:0] IDX_HEARD2 = 16'd1;
    localparam logic [15:0] IDX_HEARD3 = 16'd2;

    state_t      state;
    logic [15:0] idx;
    logic [15:0] rem;
    logic [1:0]  pcnt;
    logic [31:0] payload [3];

    logic [15:0] hdr_idx;
    logic [15:0] hdr_len;
    logic        hdr_valid;
    logic        accept;
    logic        dispatching;
    logic        fire;

    assign hdr_idx   = pipe_enq_v[31:16];
    assign hdr_len   = pipe_enq_v[15:0];
    assign hdr_valid = (hdr_idx == IDX_HEARD  && hdr_len == 16'd2) ||
                       (hdr_idx == IDX_HEARD2 && hdr_len == 16'd2) ||
                       (hdr_idx == IDX_HEARD3 && hdr_len == 16'd4);

    // Held low during reset so nothing upstream mistakes the reset window for free space.
    assign pipe_enq__RDY = nRST && (state != DISPATCH);
    assign accept        = pipe_enq__ENA && pipe_enq__RDY;

    // ENA is a pure function of state and the sink's RDY, never of itself.
    assign dispatching        = (state == DISPATCH);
    assign method_heard__ENA  = dispatching && (idx == IDX_HEARD)  && method_heard__RDY;
    assign method_heard2__ENA = dispatching && (idx == IDX_HEARD2) && method_heard2__RDY;
    assign method_heard3__ENA = dispatching && (idx == IDX_HEARD3) && method_heard3__RDY;
    assign fire = method_heard__ENA || method_heard2__ENA || method_heard3__ENA;

    // Payload is the 96 bits following the header, low word first.
    assign method_heard_v  = payload[0];
    assign method_heard2_a = payload[0][15:0];
    assign method_heard2_b = payload[0][31:16];
    assign method_heard3_a = payload[0][15:0];
    assign method_heard3_b = {payload[1][15:0], payload[0][31:16]};
    assign method_heard3_c = {payload[2][15:0], payload[1][31:16]};
    assign method_heard3_d = payload[2][31:16];

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= HDR;
            idx       <= '0;
            rem       <= '0;
            pcnt      <= '0;
            // NOTE: the small payload array is reset explicitly; it is flops, not a RAM.
            payload[0] <= '0;
            payload[1] <= '0;
            payload[2] <= '0;
            err_count <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (accept) begin
                        if (hdr_valid) begin
                            idx   <= hdr_idx;
                            rem   <= hdr_len - 16'd1;
                            pcnt  <= '0;
                            state <= BODY;
                        end else begin
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_WIDTH'(1);
                            end
                            if (hdr_len > 16'd1) begin
                                rem   <= hdr_len - 16'd1;
                                state <= DISCARD;
                            end
                        end
                    end
                end
                BODY: begin
                    if (accept) begin
                        payload[pcnt] <= pipe_enq_v;
                        pcnt          <= pcnt + 2'd1;
                        rem           <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            state <= DISPATCH;
                        end
                    end
                end
                DISCARD: begin
                    if (accept) begin
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            state <= HDR;
                        end
                    end
                end
                DISPATCH: begin
                    if (fire) begin
                        state <= HDR;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_indication_p2m.sv
// Self-checking bench for echo_indication_p2m: directed vector table, reset sequences and
// randomized messages checked against a message-level reference model.
module tb_echo_indication_p2m;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        enq_ena;
    logic [31:0] enq_v;
    logic [2:0]  rdy;

    logic        p_rdy, h1_ena, h2_ena, h3_ena;
    logic [31:0] h1_v, h3_b, h3_c;
    logic [15:0] h2_a, h2_b, h3_a, h3_d;
    logic [7:0]  err1;

    logic        q_rdy, q1_ena, q2_ena, q3_ena;
    logic [31:0] q1_v, q3_b, q3_c;
    logic [15:0] q2_a, q2_b, q3_a, q3_d;
    logic [1:0]  err2;

    echo_indication_p2m dut (
        .CLK(CLK), .nRST(nRST),
        .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v), .pipe_enq__RDY(p_rdy),
        .method_heard__ENA(h1_ena), .method_heard_v(h1_v), .method_heard__RDY(rdy[0]),
        .method_heard2__ENA(h2_ena), .method_heard2_a(h2_a), .method_heard2_b(h2_b),
        .method_heard2__RDY(rdy[1]),
        .method_heard3__ENA(h3_ena), .method_heard3_a(h3_a), .method_heard3_b(h3_b),
        .method_heard3_c(h3_c), .method_heard3_d(h3_d), .method_heard3__RDY(rdy[2]),
        .err_count(err1)
    );

    echo_indication_p2m #(.ERR_WIDTH(2)) dut2 (
        .CLK(CLK), .nRST(nRST),
        .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v), .pipe_enq__RDY(q_rdy),
        .method_heard__ENA(q1_ena), .method_heard_v(q1_v), .method_heard__RDY(rdy[0]),
        .method_heard2__ENA(q2_ena), .method_heard2_a(q2_a), .method_heard2_b(q2_b),
        .method_heard2__RDY(rdy[1]),
        .method_heard3__ENA(q3_ena), .method_heard3_a(q3_a), .method_heard3_b(q3_b),
        .method_heard3_c(q3_c), .method_heard3_d(q3_d), .method_heard3__RDY(rdy[2]),
        .err_count(err2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          dut;
        int          cyc;
        int          which;
        logic [31:0] f0, f1, f2, f3;
    } call_t;

    typedef struct {
        string       name;
        logic [31:0] w0, w1, w2, w3;
        int          n;
        int          dly;
        int          which;
        logic [31:0] e0, e1, e2, e3;
        int          err;
    } vec_t;

    call_t calls [$];
    int    cyc     = 0;
    int    checks  = 0;
    int    errors  = 0;
    int    err_exp = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every method call observed on either DUT, in dut order within a cycle.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (h1_ena) calls.push_back('{dut:0, cyc:cyc, which:0, f0:h1_v, f1:32'h0, f2:32'h0, f3:32'h0});
            if (h2_ena) calls.push_back('{dut:0, cyc:cyc, which:1, f0:{16'h0, h2_a}, f1:{16'h0, h2_b}, f2:32'h0, f3:32'h0});
            if (h3_ena) calls.push_back('{dut:0, cyc:cyc, which:2, f0:{16'h0, h3_a}, f1:h3_b, f2:h3_c, f3:{16'h0, h3_d}});
            if (q1_ena) calls.push_back('{dut:1, cyc:cyc, which:0, f0:q1_v, f1:32'h0, f2:32'h0, f3:32'h0});
            if (q2_ena) calls.push_back('{dut:1, cyc:cyc, which:1, f0:{16'h0, q2_a}, f1:{16'h0, q2_b}, f2:32'h0, f3:32'h0});
            if (q3_ena) calls.push_back('{dut:1, cyc:cyc, which:2, f0:{16'h0, q3_a}, f1:q3_b, f2:q3_c, f3:{16'h0, q3_d}});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic int model_which(input logic [31:0] h);
        int hidx;
        int hlen;
        hidx = int'(h[31:16]);
        hlen = int'(h[15:0]);
        if (hlen == 2 && hidx <= 1) return hidx;
        if (hlen == 4 && hidx == 2) return 2;
        return -1;
    endfunction

    task automatic check_errs(input string name);
        check({name, "_err8"}, 64'(err1), 64'(sat(err_exp, 255)));
        check({name, "_err2"}, 64'(err2), 64'(sat(err_exp, 3)));
    endtask

    // Sends one message, then expects either exactly one call per DUT (ew >= 0) in the
    // cycle after the last word plus the sink stall, or no call at all.
    task automatic do_msg(input string name, input logic [31:0] w0, w1, w2, w3,
                          input int n, input int dly, input int ew,
                          input logic [31:0] e0, e1, e2, e3);
        logic [31:0] w [4];
        int    last;
        int    k;
        call_t c;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        last = 0;
        rdy = 3'($urandom_range(0, 7));
        if (ew >= 0) rdy[ew] = (dly == 0);
        for (int i = 0; i < n; i++) begin
            enq_ena = 1'b1;
            enq_v   = (i < 4) ? w[i] : $urandom;
            @(negedge CLK); #1;
            check({name, "_enq_rdy"}, 64'({p_rdy, q_rdy}), 64'd3);
            last = cyc;
            @(posedge CLK); #1;
        end
        enq_ena = 1'b0;
        if (ew >= 0) begin
            for (int s = 0; s < dly; s++) begin
                @(negedge CLK); #1;
                check({name, "_stall"}, 64'({p_rdy, h1_ena, h2_ena, h3_ena}), 64'd0);
                @(posedge CLK); #1;
            end
            rdy = 3'b111;
            @(negedge CLK); #1;
            k = 0;
            while (calls.size() < 2 && k < 10) begin
                @(posedge CLK); #1;
                @(negedge CLK); #1;
                k++;
            end
            check({name, "_call_seen"}, 64'(calls.size() >= 2), 64'd1);
            for (int d = 0; d < 2 && calls.size() > 0; d++) begin
                c = calls.pop_front();
                check({name, "_dut"}, 64'(c.dut), 64'(d));
                check({name, "_cycle"}, 64'(c.cyc), 64'(last + 1 + dly));
                check({name, "_which"}, 64'(c.which), 64'(ew));
                check({name, "_f0"}, 64'(c.f0), 64'(e0));
                check({name, "_f1"}, 64'(c.f1), 64'(e1));
                check({name, "_f2"}, 64'(c.f2), 64'(e2));
                check({name, "_f3"}, 64'(c.f3), 64'(e3));
            end
        end
        repeat (2) begin
            @(posedge CLK); #1;
        end
        @(negedge CLK); #1;
        check({name, "_no_extra_call"}, 64'(calls.size()), 64'd0);
        calls.delete();
        check({name, "_enq_rdy_after"}, 64'({p_rdy, q_rdy}), 64'd3);
        check_errs(name);
        @(posedge CLK); #1;
    endtask

    task automatic do_reset(input string name);
        @(posedge CLK); #2;
        nRST = 1'b0;
        #1;
        check({name, "_rdy_in_reset"}, 64'({p_rdy, q_rdy}), 64'd0);
        check({name, "_ena_in_reset"}, 64'({h1_ena, h2_ena, h3_ena, q1_ena, q2_ena, q3_ena}), 64'd0);
        err_exp = 0;
        check_errs({name, "_in_reset"});
        check({name, "_no_call"}, 64'(calls.size()), 64'd0);
        calls.delete();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK); #1;
        check({name, "_rdy_after_reset"}, 64'({p_rdy, q_rdy}), 64'd3);
        @(posedge CLK); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [7];
        logic [31:0] hdr;
        logic [31:0] r1, r2, r3;
        logic [127:0] msg;
        int          which;
        int          hlen;
        int          n;
        int          dly;
        logic [31:0] e0, e1, e2, e3;

        tbl[0] = '{"heard",      32'h00000002, 32'hDEADBEEF, 32'h0, 32'h0, 2, 0,  0,
                   32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 0};
        tbl[1] = '{"heard2",     32'h00010002, 32'hBBBBAAAA, 32'h0, 32'h0, 2, 0,  1,
                   32'h0000AAAA, 32'h0000BBBB, 32'h0, 32'h0, 0};
        tbl[2] = '{"heard3",     32'h00020004, 32'h22221111, 32'h33334444, 32'h55556666, 4, 0, 2,
                   32'h00001111, 32'h44442222, 32'h66663333, 32'h00005555, 0};
        tbl[3] = '{"backpress",  32'h00000002, 32'hCAFEF00D, 32'h0, 32'h0, 2, 5,  0,
                   32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 0};
        tbl[4] = '{"bad_len3",   32'h00070003, 32'h00000001, 32'h00000002, 32'h0, 3, 0, -1,
                   32'h0, 32'h0, 32'h0, 32'h0, 1};
        tbl[5] = '{"after_bad",  32'h00000002, 32'h12345678, 32'h0, 32'h0, 2, 0,  0,
                   32'h12345678, 32'h0, 32'h0, 32'h0, 1};
        tbl[6] = '{"bad_len1",   32'h00050001, 32'h0, 32'h0, 32'h0, 1, 0, -1,
                   32'h0, 32'h0, 32'h0, 32'h0, 2};

        nRST    = 1'b1;
        enq_ena = 1'b0;
        enq_v   = '0;
        rdy     = 3'b111;
        do_reset("init");

        for (int i = 0; i < 7; i++) begin
            err_exp = tbl[i].err;
            do_msg(tbl[i].name, tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3,
                   tbl[i].n, tbl[i].dly, tbl[i].which,
                   tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3);
        end

        // Five bad headers from a clean count: the 2-bit counter pins at 3.
        do_reset("sat_reset");
        for (int i = 0; i < 5; i++) begin
            err_exp++;
            do_msg("sat_bad", 32'h00090001, 32'h0, 32'h0, 32'h0, 1, 0, -1,
                   32'h0, 32'h0, 32'h0, 32'h0);
        end
        check("sat_err2_final", 64'(err2), 64'd3);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       hdr = 32'h00000002;
                1:       hdr = 32'h00010002;
                2:       hdr = 32'h00020004;
                default: hdr = {16'($urandom_range(0, 4)), 16'($urandom_range(0, 6))};
            endcase
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            which = model_which(hdr);
            hlen  = int'(hdr[15:0]);
            n     = (hlen <= 1) ? 1 : hlen;
            msg   = {r3, r2, r1, hdr};
            e0 = '0; e1 = '0; e2 = '0; e3 = '0;
            dly = 0;
            case (which)
                0: e0 = msg[63:32];
                1: begin
                    e0 = {16'h0, msg[47:32]};
                    e1 = {16'h0, msg[63:48]};
                end
                2: begin
                    e0 = {16'h0, msg[47:32]};
                    e1 = msg[79:48];
                    e2 = msg[111:80];
                    e3 = {16'h0, msg[127:112]};
                end
                default: err_exp++;
            endcase
            if (which >= 0) dly = $urandom_range(0, 3);
            do_msg("rand", hdr, r1, r2, r3, n, dly, which, e0, e1, e2, e3);
        end

        // Reset after two words of a heard3 message: message abandoned, no call.
        rdy = 3'b111;
        enq_ena = 1'b1;
        enq_v = 32'h00020004;
        @(posedge CLK); #1;
        enq_v = 32'h22221111;
        @(posedge CLK); #1;
        enq_ena = 1'b0;
        do_reset("mid_msg");
        do_msg("post_reset_heard", 32'h00000002, 32'h0BADCAFE, 32'h0, 32'h0, 2, 0, 0,
               32'h0BADCAFE, 32'h0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
